// File: rtl/alu_pkg.sv
// Shared ALU opcode/flag constants and the in-flight response tag used by alu_arbiter.
// Used together with rr_arbiter and alu_arbiter; the optional feature is ALU_ARB_LOCK_EN.
package alu_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int OP_W_DEF   = 6;
  // Wide enough for the largest requester count (8); the top resizes it to ID_W.
  localparam int MAX_ID_W   = 3;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_XOR   = 6'd4;
  localparam logic [5:0] OP_NOTA  = 6'd5;
  localparam logic [5:0] OP_SHL   = 6'd6;
  localparam logic [5:0] OP_SHR   = 6'd7;
  localparam logic [5:0] OP_INC   = 6'd8;
  localparam logic [5:0] OP_PASSA = 6'd9;
  localparam logic [5:0] OP_PASSB = 6'd10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
  } resp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr, wrapping, wins.
// Latency is zero and there is no internal state, so the caller owns and updates the pointer.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU; responses return 2 cycles after acceptance, one op per cycle.
// Responses cannot be stalled; the optional ALU_ARB_LOCK_EN build adds req_lock to keep priority on a requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*WORD_W-1:0] req_a,
  input  logic [NUM_REQ*WORD_W-1:0] req_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [WORD_W-1:0]         alu_a,
  output logic [WORD_W-1:0]         alu_b,
  input  logic [WORD_W-1:0]         alu_d_out,
  input  logic [3:0]                alu_flags,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [WORD_W-1:0]         resp_data,
  output logic [3:0]                resp_flags,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, gnt_id, nxt_ptr;
  logic [NUM_REQ-1:0] gnt_raw, gnt;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [WORD_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  resp_tag_t          stage1_q, stage1_d, stage2_q, stage2_d;
  logic               fire, hold_ptr;

  rr_arbiter #(.N(NUM_REQ), .IDW(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt_raw),
    .id    (gnt_id)
  );

  // Nothing may be granted while reset is held, even though the arbiter itself is stateless.
  assign gnt       = rst ? '0 : gnt_raw;
  assign fire      = |gnt;
  assign req_ready = gnt;
  assign nxt_ptr   = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ALU_ARB_LOCK_EN
  assign hold_ptr = |(gnt & req_lock);
`else
  assign hold_ptr = 1'b0;
`endif

  always_comb begin
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        alu_op_d = req_op[i*OP_W +: OP_W];
        alu_a_d  = req_a[i*WORD_W +: WORD_W];
        alu_b_d  = req_b[i*WORD_W +: WORD_W];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (fire) rr_ptr_d = hold_ptr ? gnt_id : nxt_ptr;
    stage1_d.v  = fire;
    stage1_d.id = MAX_ID_W'(gnt_id);
    // The ALU registers its result one edge after issue; stage2 lines up with that result.
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign busy   = stage1_q.v | stage2_q.v;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = stage2_q.v && (stage2_q.id == MAX_ID_W'(i));
    end
    resp_id    = stage2_q.v ? ID_W'(stage2_q.id) : '0;
    resp_data  = stage2_q.v ? alu_d_out : '0;
    resp_flags = stage2_q.v ? alu_flags : '0;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, then random traffic against a queue-based reference.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*6-1:0] req_op;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [5:0]     alu_op;
  logic [7:0]     alu_a, alu_b;
  logic [7:0]     alu_d_out;
  logic [3:0]     alu_flags;
  logic [N-1:0]   resp_valid;
  logic [1:0]     resp_id;
  logic [7:0]     resp_data;
  logic [3:0]     resp_flags;
  logic           busy;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
  logic [N-1:0]   r_lk;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .WORD_W(8), .OP_W(6), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_d_out  (alu_d_out),
    .alu_flags  (alu_flags),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_flags (resp_flags),
    .busy       (busy)
  );

  // Reference ALU: returns {flags[3:0], result[7:0]}; undefined opcodes give 0 with Z set.
  function automatic logic [11:0] alu_ref(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic [3:0] f;
    w = '0; r = '0; f = '0;
    case (op)
      OP_ADD:   begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; f[FLAG_C] = w[8];
                      f[FLAG_V] = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB:   begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; f[FLAG_C] = ~w[8];
                      f[FLAG_V] = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOTA:  r = ~a;
      OP_SHL:   begin r = a << 1; f[FLAG_C] = a[7]; end
      OP_SHR:   begin r = a >> 1; f[FLAG_C] = a[0]; end
      OP_INC:   r = a + 8'd1;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = '0;
    endcase
    f[FLAG_N] = r[7];
    f[FLAG_Z] = (r == 8'h00);
    return {f, r};
  endfunction

  // Stand-in for the registered ALU instance.
  always @(posedge clk) {alu_flags, alu_d_out} <= alu_ref(alu_op, alu_a, alu_b);

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] lk;
    logic [5:0] op;
    logic [7:0] a, b;
    logic [3:0] e_rdy, e_rv;
    logic [1:0] e_id;
    logic [7:0] e_dat;
    logic [3:0] e_flg;
    logic       e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] lk, input logic [5:0] op,
                     input logic [7:0] a, input logic [7:0] b, input logic [3:0] e_rdy, input logic [3:0] e_rv,
                     input logic [1:0] e_id, input logic [7:0] e_dat, input logic [3:0] e_flg, input logic e_busy);
    vec_t t;
    t.rst = r; t.v = v; t.lk = lk; t.op = op; t.a = a; t.b = b;
    t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_id = e_id; t.e_dat = e_dat; t.e_flg = e_flg; t.e_busy = e_busy;
    vq.push_back(t);
  endtask

  // Random-phase requester state and reference model.
  logic [N-1:0] pend;
  logic [5:0]   r_op [N];
  logic [7:0]   r_a  [N];
  logic [7:0]   r_b  [N];

  typedef struct {
    int          due;
    int          id;
    logic [11:0] res;
  } exp_t;

  exp_t exp_q[$];

  task automatic drive(input logic r);
    rst       = r;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_op[i*6 +: 6] = r_op[i];
      req_a[i*8 +: 8]  = r_a[i];
      req_b[i*8 +: 8]  = r_b[i];
    end
`ifdef ALU_ARB_LOCK_EN
    req_lock = r_lk;
`endif
  endtask

  initial begin
    vec_t  t;
    int    m_ptr, g, cyc;
    logic  r;
    logic [3:0]  e_rv;
    logic [1:0]  e_id;
    logic [11:0] e_res;

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0; r_lk = '0;
`endif

    // rst v lk op a b | rdy rv id data flags busy
    add(1, 4'b0001, 4'b0, OP_ADD, 8'h7F, 8'h01, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0001, 4'b0, OP_ADD, 8'h7F, 8'h01, 4'b0001, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0001, 2'd0, 8'h80, 4'b1001, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(1, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b1111, 4'b0, OP_SUB, 8'h05, 8'h03, 4'b0001, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b1111, 4'b0, OP_SUB, 8'h05, 8'h03, 4'b0010, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b1111, 4'b0, OP_SUB, 8'h05, 8'h03, 4'b0100, 4'b0001, 2'd0, 8'h02, 4'b0010, 1);
    add(0, 4'b1111, 4'b0, OP_SUB, 8'h05, 8'h03, 4'b1000, 4'b0010, 2'd1, 8'h02, 4'b0010, 1);
    add(0, 4'b1111, 4'b0, OP_SUB, 8'h05, 8'h03, 4'b0001, 4'b0100, 2'd2, 8'h02, 4'b0010, 1);
    add(0, 4'b0000, 4'b0, OP_SUB, 8'h00, 8'h00, 4'b0000, 4'b1000, 2'd3, 8'h02, 4'b0010, 1);
    add(0, 4'b0000, 4'b0, OP_SUB, 8'h00, 8'h00, 4'b0000, 4'b0001, 2'd0, 8'h02, 4'b0010, 1);
    add(0, 4'b0000, 4'b0, OP_SUB, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0100, 4'b0, OP_AND, 8'hAA, 8'h0F, 4'b0100, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0100, 4'b0, OP_OR,  8'hA0, 8'h0F, 4'b0100, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b0100, 4'b0, OP_XOR, 8'hFF, 8'h0F, 4'b0100, 4'b0100, 2'd2, 8'h0A, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0100, 2'd2, 8'hAF, 4'b1000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0100, 2'd2, 8'hF0, 4'b1000, 1);
    add(0, 4'b1001, 4'b0, OP_ADD, 8'h01, 8'h02, 4'b1000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b1001, 4'b0, OP_ADD, 8'h01, 8'h02, 4'b0001, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b1000, 2'd3, 8'h03, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0001, 2'd0, 8'h03, 4'b0000, 1);
    add(0, 4'b0010, 4'b0, OP_ADD, 8'hFF, 8'h01, 4'b0010, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(1, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0011, 4'b0, OP_ADD, 8'h01, 8'h01, 4'b0001, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0001, 2'd0, 8'h02, 4'b0000, 1);
    add(0, 4'b0000, 4'b0, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
`ifdef ALU_ARB_LOCK_EN
    add(0, 4'b0111, 4'b0010, OP_ADD, 8'h01, 8'h01, 4'b0010, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
    add(0, 4'b0111, 4'b0010, OP_ADD, 8'h01, 8'h01, 4'b0010, 4'b0000, 2'd0, 8'h00, 4'b0000, 1);
    add(0, 4'b0111, 4'b0000, OP_ADD, 8'h01, 8'h01, 4'b0010, 4'b0010, 2'd1, 8'h02, 4'b0000, 1);
    add(0, 4'b0101, 4'b0000, OP_ADD, 8'h01, 8'h01, 4'b0100, 4'b0010, 2'd1, 8'h02, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0010, 2'd1, 8'h02, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0100, 2'd2, 8'h02, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, OP_ADD, 8'h00, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00, 4'b0000, 0);
`endif

    foreach (vq[k]) begin
      t = vq[k];
      @(posedge clk); #1;
      rst       = t.rst;
      req_valid = t.v;
      for (int i = 0; i < N; i++) begin
        req_op[i*6 +: 6] = t.op;
        req_a[i*8 +: 8]  = t.a;
        req_b[i*8 +: 8]  = t.b;
      end
`ifdef ALU_ARB_LOCK_EN
      req_lock = t.lk;
`endif
      @(negedge clk);
      chk($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(t.e_rdy));
      chk($sformatf("vec%0d resp_valid", k), 32'(resp_valid), 32'(t.e_rv));
      chk($sformatf("vec%0d resp_id", k), 32'(resp_id), 32'(t.e_id));
      chk($sformatf("vec%0d resp_data", k), 32'(resp_data), 32'(t.e_dat));
      chk($sformatf("vec%0d resp_flags", k), 32'(resp_flags), 32'(t.e_flg));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(t.e_busy));
      if (t.rst) chk($sformatf("vec%0d alu regs in reset", k), {8'h0, alu_op, alu_a, alu_b}, 32'h0);
    end

    // Random traffic: requesters hold a request until granted; one reset pulse mid-run.
    pend = '0; m_ptr = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      r = (c < 2) || (c == 300) || (c == 301);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1'b1;
          r_op[i] = 6'($urandom_range(0, 15));
          r_a[i]  = 8'($urandom);
          r_b[i]  = 8'($urandom);
`ifdef ALU_ARB_LOCK_EN
          r_lk[i] = ($urandom_range(0, 3) == 0);
`endif
        end
      end
      @(posedge clk); #1;
      drive(r);
      @(negedge clk);
      g = -1;
      if (r) begin
        exp_q.delete();
        m_ptr = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      chk("rnd busy", 32'(busy), 32'(exp_q.size() != 0));
      e_rv = '0; e_id = '0; e_res = '0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e_rv  = 4'(1 << exp_q[0].id);
        e_id  = 2'(exp_q[0].id);
        e_res = exp_q[0].res;
        void'(exp_q.pop_front());
      end
      chk("rnd req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rnd resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("rnd resp_id", 32'(resp_id), 32'(e_id));
      chk("rnd resp_data", 32'(resp_data), 32'(e_res[7:0]));
      chk("rnd resp_flags", 32'(resp_flags), 32'(e_res[11:8]));
      if (g >= 0) begin
        exp_t e;
        e.due = cyc + 2;
        e.id  = g;
        e.res = alu_ref(r_op[g], r_a[g], r_b[g]);
        exp_q.push_back(e);
        m_ptr = (g + 1) % N;
`ifdef ALU_ARB_LOCK_EN
        if (r_lk[g]) m_ptr = g;
`endif
        pend[g] = 1'b0;
      end
      cyc++;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one registered ALU (1-cycle input-to-output latency, NZCV flags) among NUM_REQ requesters. Round-robin grant, registered issue stage and an in-flight tag pipeline sustain one operation per cycle. Each response is returned to its requester with its id. Sits between the decode/microcode requesters and the ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_W, 8, operand/result width
OP_W, 6, opcode width
ID_W, 2, requester id width; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&&ready
req_op  in  NUM_REQ*OP_W  flattened opcodes, requester i at [i*OP_W +: OP_W]
req_a  in  NUM_REQ*WORD_W  flattened operand A
req_b  in  NUM_REQ*WORD_W  flattened operand B
alu_op  out  OP_W  registered opcode to ALU
alu_a  out  WORD_W  registered operand A to ALU (ALU d_in0)
alu_b  out  WORD_W  registered operand B to ALU (ALU d_in1)
alu_d_out  in  WORD_W  ALU result
alu_flags  in  4  ALU flags, N=3 Z=2 C=1 V=0
resp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle
resp_id  out  ID_W  id of responding requester
resp_data  out  WORD_W  result
resp_flags  out  4  flags, same bit layout as ALU
busy  out  1  any operation in flight

Behaviour:
- Reset (async, rst=1): alu_op/alu_a/alu_b=0, rr_ptr=0, in-flight valid bits=0. Responses for ops accepted before reset are dropped. Outputs while in reset: req_ready=0, resp_valid=0, resp_id=0, busy=0.
- Arbitration is combinational each cycle. Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. First hit g gets req_ready[g]=1. No valid request gives req_ready=0.
- req_ready depends on req_valid. Requesters must not make valid depend on ready. A requester holds valid/op/a/b stable until it is granted.
- On grant at edge k: alu_* <= req_*[g], stage1 <= {1,g}, rr_ptr <= (g+1) mod NUM_REQ. With no grant: stage1.v <= 0, alu_* and rr_ptr hold.
- At edge k+1 the ALU registers its result and stage2 <= stage1.
- During cycle k+2: stage2.v=1 gives resp_valid[stage2.id]=1, resp_id=stage2.id, resp_data=alu_d_out, resp_flags=alu_flags. Total latency is 2 cycles from acceptance. There is no response backpressure; requesters must sink the strobe.
- When stage2.v=0: resp_valid=0, resp_id/data/flags=0.
- busy = stage1.v | stage2.v.
- Throughput is one grant per cycle, back-to-back, including repeated grants to a sole requester.
- Undefined opcodes (>10) pass through unchanged. The ALU returns 0 with Z=1 and the arbiter does not check.
- rst deassertion takes effect on the next posedge. The first grant is possible at that edge.

Optional Feature:
ALU_ARB_LOCK_EN
- Defined: adds input req_lock [NUM_REQ]. If the granted requester g has req_lock[g]=1, rr_ptr <= g instead of g+1, so g keeps top priority while its valid and lock stay high. This gives atomic multi-op sequences such as multi-byte add with carry. When lock is dropped, rotation resumes from g+1.
- Undefined: no port, plain round-robin.

Decomposition:
- Package alu_pkg: OP_ADD..OP_PASSB opcode constants (0..10), FLAG_N/Z/C/V bit indices, default WORD_W/OP_W, a response-tag struct typedef {v, id}.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr; output one-hot grant and encoded id. It is purely combinational and reusable for the bus arbiter.

Test Plan:
1. Single op: req0 ADD a=0x7F b=0x01. Expect req_ready[0] in cycle 0; resp_valid[0] in cycle 2, data=0x80, flags=1001, resp_id=0.
2. All four requesters valid continuously, each SUB with a=0x05 b=0x03. Expect grants 0,1,2,3,0 on consecutive cycles and responses 2 cycles behind in the same order, data=0x02, flags=0010.
3. Only req2 valid for 3 cycles with AND 0xAA&0x0F, OR 0xA0|0x0F, XOR 0xFF^0x0F. Expect back-to-back responses 0x0A, 0xAF, 0xF0, all id=2, and busy high throughout.
4. Accept req1 ADD 0xFF+0x01, then assert rst during cycle 1. Expect no resp_valid after reset, alu_* =0, and first grant after reset goes to req0 (rr_ptr=0).
5. Pointer wrap: rr_ptr=3 after granting req2, req0 and req3 valid. Expect req3 granted first, then req0.
6. Lock (ALU_ARB_LOCK_EN defined): req1 with lock=1 issues 3 ops while req0/req2 are valid. Expect grants 1,1,1, then 2 after lock drops.
